io_bus_ctrl: RTL and testbench

Parametrised I/O-space bus controller that sits between the V810 bus signals decoded by the gate array and up to NCH 16-bit peripherals, such as the VCE, the VDCs and the MMC. It turns a CPU bus cycle into RDn/WRn strobes with a programmable minimum wait and per-channel BUSYn stretching. It latches read data from the selected channel and generates READYn for the CPU. It also adds what the fixed combinational I/O mux lacks: a bus-timeout watchdog, open-bus read data, multi-select error detection and abort handling.

---
 rtl/io_bus_ctrl_if.sv | 34 +++
 rtl/io_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_io_bus_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_ctrl_if.sv
// Bus bundle between the decoded V810 I/O cycle signals and the bus controller.
// The controller takes the slave side; the CPU/gate-array side is the master.
interface io_bus_ctrl_if #(
   parameter int NCH = 8,
   parameter int DW  = 16
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   // Cycle request from the CPU side
   logic              BCYSTn;
   logic              RW;
   logic [NCH-1:0]    CSn;
   // Peripheral channel returns
   logic [NCH*DW-1:0] CH_DO;
   logic [NCH-1:0]    CH_BUSYn;
   // Controller outputs
   logic              RDn;
   logic              WRn;
   logic [DW-1:0]     DO;
   logic              READYn;
   logic [SW-1:0]     SEL;
   logic              TMO_ERR;
   logic              MSEL_ERR;

   modport slave (
      input  BCYSTn, RW, CSn, CH_DO, CH_BUSYn,
      output RDn, WRn, DO, READYn, SEL, TMO_ERR, MSEL_ERR
   );

   modport master (
      output BCYSTn, RW, CSn, CH_DO, CH_BUSYn,
      input  RDn, WRn, DO, READYn, SEL, TMO_ERR, MSEL_ERR
   );
endinterface

// File: rtl/io_bus_ctrl.sv
// I/O-space bus controller: turns a CPU bus cycle into RDn/WRn strobes with a
// minimum wait, per-channel BUSYn stretching, a timeout watchdog returning
// open-bus data, multi-select detection and abort on select release.
module io_bus_ctrl #(
   parameter int            NCH      = 8,
   parameter int            DW       = 16,
   parameter int            MIN_WAIT = 2,
   parameter int            TIMEOUT  = 255,
   parameter logic [DW-1:0] OPEN_BUS = '1
) (
   input  logic         CLK,
   input  logic         RESn,
   input  logic         CE,
   io_bus_ctrl_if.slave bus
);
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   // W is cleared on the start tick, so completion is allowed once it has
   // counted MIN_WAIT-1 further ticks; timeout fires on the tick that reaches
   // TIMEOUT ticks after the strobe went low.
   localparam logic [WW-1:0] W_MIN = WW'(MIN_WAIT - 1);
   localparam logic [WW-1:0] W_TMO = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] W_SAT = WW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, STROBE, DONE} state_t;

   state_t         state_reg, state_next;
   logic [WW-1:0]  w_reg, w_next;
   logic [SW-1:0]  sel_reg, sel_next;
   logic           rw_reg, rw_next;
   logic [DW-1:0]  do_reg, do_next;
   logic           rdn_reg, rdn_next;
   logic           wrn_reg, wrn_next;
   logic           readyn_reg, readyn_next;
   logic           tmo_reg, tmo_next;
   logic           msel_reg, msel_next;

   logic [DW-1:0]  ch_data [NCH];
   logic [NCH-1:0] cs_act;
   logic           start;
   logic           multi_sel;
   logic [SW-1:0]  first_idx;
   logic           sel_busy_n;
   logic           sel_cs_n;

   // Split the flat channel data bus into one word per channel
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_data[gi] = bus.CH_DO[gi*DW +: DW];
   end

   assign cs_act     = ~bus.CSn;
   assign start      = ~bus.BCYSTn & (|cs_act);
   // More than one bit set <=> clearing the lowest set bit leaves something
   assign multi_sel  = |(cs_act & (cs_act - NCH'(1)));
   assign sel_busy_n = bus.CH_BUSYn[sel_reg];
   assign sel_cs_n   = bus.CSn[sel_reg];

   // Priority encoder: lowest channel index with its select asserted
   always_comb begin
      first_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (cs_act[i]) first_idx = SW'(i);
      end
   end

   // Next-state and output logic; pulses default low, READYn defaults high
   always_comb begin
      state_next  = state_reg;
      w_next      = w_reg;
      sel_next    = sel_reg;
      rw_next     = rw_reg;
      do_next     = do_reg;
      rdn_next    = rdn_reg;
      wrn_next    = wrn_reg;
      readyn_next = 1'b1;
      tmo_next    = 1'b0;
      msel_next   = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            state_next = IDLE;
            rdn_next   = 1'b1;
            wrn_next   = 1'b1;
            if (start) begin
               state_next = STROBE;
               w_next     = '0;
               sel_next   = first_idx;
               rw_next    = bus.RW;
               rdn_next   = ~bus.RW;
               wrn_next   = bus.RW;
               msel_next  = multi_sel;
            end
         end
         STROBE: begin
            w_next = (w_reg == W_SAT) ? w_reg : w_reg + WW'(1);
            if (sel_cs_n) begin
               // Abort: selected channel released its select, drop quietly
               state_next = IDLE;
               rdn_next   = 1'b1;
               wrn_next   = 1'b1;
            end else if ((w_reg >= W_MIN) && sel_busy_n) begin
               state_next  = DONE;
               rdn_next    = 1'b1;
               wrn_next    = 1'b1;
               readyn_next = 1'b0;
               if (rw_reg) do_next = ch_data[sel_reg];
            end else if (w_reg == W_TMO) begin
               state_next  = DONE;
               rdn_next    = 1'b1;
               wrn_next    = 1'b1;
               readyn_next = 1'b0;
               tmo_next    = 1'b1;
               if (rw_reg) do_next = OPEN_BUS;
            end
         end
         default: begin
            state_next = IDLE;
            rdn_next   = 1'b1;
            wrn_next   = 1'b1;
         end
      endcase
   end

   // State and output registers; advance only on CE, reset asynchronously
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state_reg  <= IDLE;
         w_reg      <= '0;
         sel_reg    <= '0;
         rw_reg     <= 1'b0;
         do_reg     <= '0;
         rdn_reg    <= 1'b1;
         wrn_reg    <= 1'b1;
         readyn_reg <= 1'b1;
         tmo_reg    <= 1'b0;
         msel_reg   <= 1'b0;
      end else if (CE) begin
         state_reg  <= state_next;
         w_reg      <= w_next;
         sel_reg    <= sel_next;
         rw_reg     <= rw_next;
         do_reg     <= do_next;
         rdn_reg    <= rdn_next;
         wrn_reg    <= wrn_next;
         readyn_reg <= readyn_next;
         tmo_reg    <= tmo_next;
         msel_reg   <= msel_next;
      end
   end

   assign bus.RDn      = rdn_reg;
   assign bus.WRn      = wrn_reg;
   assign bus.DO       = do_reg;
   assign bus.READYn   = readyn_reg;
   assign bus.SEL      = sel_reg;
   assign bus.TMO_ERR  = tmo_reg;
   assign bus.MSEL_ERR = msel_reg;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: reads, stretched writes, timeout,
// multi-select, abort, reset mid-strobe with CE low, back-to-back reads.
module tb_io_bus_ctrl;
   localparam int NCH = 8;
   localparam int DW  = 16;

   logic clk;
   logic rst_n;
   logic ce;
   int   total;
   int   bad;

   io_bus_ctrl_if #(.NCH(NCH), .DW(DW)) bus ();

   io_bus_ctrl #(
      .NCH(NCH), .DW(DW), .MIN_WAIT(2), .TIMEOUT(16), .OPEN_BUS(16'hFFFF)
   ) dut (
      .CLK(clk),
      .RESn(rst_n),
      .CE(ce),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bus cycle; BUSYn of channel ch is held low for edges T0+1..T0+busy_ticks
   task automatic run_cycle(input string name, input logic rw, input logic [NCH-1:0] csn,
                            input int ch, input int busy_ticks,
                            output int strobe_ticks, output int other_ticks,
                            output int ready_at, output logic tmo_at_ready,
                            output logic msel_at_t0);
      bus.BCYSTn = 1'b0;
      bus.RW     = rw;
      bus.CSn    = csn;
      if (busy_ticks > 0) bus.CH_BUSYn[ch] = 1'b0;
      tick();
      msel_at_t0   = bus.MSEL_ERR;
      strobe_ticks = 0;
      other_ticks  = 0;
      ready_at     = -1;
      tmo_at_ready = 1'b0;
      if ((rw ? bus.RDn : bus.WRn) == 1'b0) strobe_ticks++;
      if ((rw ? bus.WRn : bus.RDn) == 1'b0) other_ticks++;
      bus.BCYSTn = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k > busy_ticks) bus.CH_BUSYn[ch] = 1'b1;
         tick();
         if (bus.READYn == 1'b0) begin
            ready_at     = k;
            tmo_at_ready = bus.TMO_ERR;
            break;
         end
         if ((rw ? bus.RDn : bus.WRn) == 1'b0) strobe_ticks++;
         if ((rw ? bus.WRn : bus.RDn) == 1'b0) other_ticks++;
      end
      bus.CH_BUSYn[ch] = 1'b1;
      $display("txn %s rw=%0d csn=%b strobe=%0d ready_at=%0d do=%h sel=%0d tmo=%0d msel=%0d",
               name, rw, csn, strobe_ticks, ready_at, bus.DO, bus.SEL, tmo_at_ready, msel_at_t0);
   endtask

   initial begin
      int   st, ot, ra, cnt;
      logic tm, ms;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      ce    = 1'b1;
      bus.BCYSTn   = 1'b1;
      bus.RW       = 1'b1;
      bus.CSn      = '1;
      bus.CH_BUSYn = '1;
      for (int i = 0; i < NCH; i++) bus.CH_DO[i*DW +: DW] = DW'(16'hC000 + i);
      bus.CH_DO[3*DW +: DW] = 16'h1234;
      bus.CH_DO[2*DW +: DW] = 16'h0BEE;

      // Reset state
      tick();
      tick();
      check_val("rst_rdn", bus.RDn, 1);
      check_val("rst_wrn", bus.WRn, 1);
      check_val("rst_readyn", bus.READYn, 1);
      check_val("rst_do", bus.DO, 0);
      check_val("rst_sel", bus.SEL, 0);
      check_val("rst_tmo", bus.TMO_ERR, 0);
      check_val("rst_msel", bus.MSEL_ERR, 0);
      $display("txn reset rdn=%0d wrn=%0d readyn=%0d do=%h", bus.RDn, bus.WRn, bus.READYn, bus.DO);
      rst_n = 1'b1;
      tick();

      // Plain read on channel 3
      run_cycle("read_ch3", 1'b1, 8'b1111_0111, 3, 0, st, ot, ra, tm, ms);
      check_val("rd3_strobe", st, 2);
      check_val("rd3_wrn", ot, 0);
      check_val("rd3_ready", ra, 2);
      check_val("rd3_do", bus.DO, 16'h1234);
      check_val("rd3_sel", bus.SEL, 3);
      check_val("rd3_msel", ms, 0);
      tick();
      check_val("rd3_ready_1tick", bus.READYn, 1);

      // Write on channel 0 stretched by BUSYn for 5 ticks
      run_cycle("write_ch0", 1'b0, 8'b1111_1110, 0, 5, st, ot, ra, tm, ms);
      check_val("wr0_strobe", st, 6);
      check_val("wr0_rdn", ot, 0);
      check_val("wr0_ready", ra, 6);
      check_val("wr0_do_kept", bus.DO, 16'h1234);
      check_val("wr0_tmo", tm, 0);
      tick();

      // Read on channel 5 with BUSYn stuck low -> watchdog
      run_cycle("timeout_ch5", 1'b1, 8'b1101_1111, 5, 1000, st, ot, ra, tm, ms);
      check_val("tmo_ready", ra, 16);
      check_val("tmo_strobe", st, 16);
      check_val("tmo_do", bus.DO, 16'hFFFF);
      check_val("tmo_pulse", tm, 1);
      tick();
      check_val("tmo_pulse_end", bus.TMO_ERR, 0);

      // Multi-select: lowest low select wins
      run_cycle("msel", 1'b1, 8'b1111_0011, 2, 0, st, ot, ra, tm, ms);
      check_val("msel_pulse", ms, 1);
      check_val("msel_sel", bus.SEL, 2);
      check_val("msel_ready", ra, 2);
      check_val("msel_do", bus.DO, 16'h0BEE);
      check_val("msel_pulse_end", bus.MSEL_ERR, 0);
      tick();

      // Abort: select released at T0+1 while BUSYn holds the cycle
      bus.CH_BUSYn[1] = 1'b0;
      bus.BCYSTn = 1'b0;
      bus.RW     = 1'b1;
      bus.CSn    = 8'b1111_1101;
      tick();
      check_val("abort_rdn_t0", bus.RDn, 0);
      check_val("abort_sel", bus.SEL, 1);
      bus.BCYSTn = 1'b1;
      bus.CSn    = '1;
      tick();
      check_val("abort_rdn_rel", bus.RDn, 1);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.READYn == 1'b0 || bus.TMO_ERR == 1'b1) cnt++;
      end
      check_val("abort_no_ready", cnt, 0);
      check_val("abort_do_kept", bus.DO, 16'h0BEE);
      bus.CH_BUSYn[1] = 1'b1;
      $display("txn abort_ch1 rdn=%0d readyn=%0d do=%h", bus.RDn, bus.READYn, bus.DO);

      // Reset mid-strobe with CE low
      bus.CH_BUSYn[4] = 1'b0;
      bus.BCYSTn = 1'b0;
      bus.CSn    = 8'b1110_1111;
      tick();
      check_val("rstmid_rdn_t0", bus.RDn, 0);
      bus.BCYSTn = 1'b1;
      ce = 1'b0;
      tick();
      tick();
      tick();
      check_val("ce_hold_rdn", bus.RDn, 0);
      #1 rst_n = 1'b0;
      #1;
      check_val("rstmid_rdn", bus.RDn, 1);
      check_val("rstmid_wrn", bus.WRn, 1);
      check_val("rstmid_readyn", bus.READYn, 1);
      check_val("rstmid_do", bus.DO, 0);
      $display("txn reset_mid rdn=%0d readyn=%0d do=%h", bus.RDn, bus.READYn, bus.DO);
      #1 rst_n = 1'b1;
      ce = 1'b1;
      bus.CH_BUSYn[4] = 1'b1;
      bus.CSn = '1;
      tick();

      // Back-to-back reads on channel 6 with BCYSTn held low
      bus.CH_DO[6*DW +: DW] = 16'hAAAA;
      bus.BCYSTn = 1'b0;
      bus.RW     = 1'b1;
      bus.CSn    = 8'b1011_1111;
      tick();
      check_val("b2b_rdn_t0", bus.RDn, 0);
      tick();
      check_val("b2b_rdn_t1", bus.RDn, 0);
      tick();
      check_val("b2b_ready1", bus.READYn, 0);
      check_val("b2b_rdn_t2", bus.RDn, 1);
      check_val("b2b_do1", bus.DO, 16'hAAAA);
      bus.CH_DO[6*DW +: DW] = 16'h5555;
      tick();
      check_val("b2b_restart_rdn", bus.RDn, 0);
      check_val("b2b_restart_readyn", bus.READYn, 1);
      tick();
      check_val("b2b_rdn_t4", bus.RDn, 0);
      bus.BCYSTn = 1'b1;
      tick();
      check_val("b2b_ready2", bus.READYn, 0);
      check_val("b2b_do2", bus.DO, 16'h5555);
      tick();
      check_val("b2b_idle_readyn", bus.READYn, 1);
      check_val("b2b_idle_rdn", bus.RDn, 1);
      $display("txn b2b_ch6 do=%h readyn=%0d", bus.DO, bus.READYn);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
